// File: rtl/rtc_bus_sequencer_if.sv
// Request and RTC AD-bus bundle for rtc_bus_sequencer.
// slave = the sequencer; master = user-mode logic plus pad side driving it.
interface rtc_bus_sequencer_if #(
    parameter int unsigned CNT_W = 6
);
    logic             date;
    logic             stime;
    logic             timer;
    logic             wr_mode;
    logic [7:0]       wr_data;
    logic [7:0]       bus_in;
    logic [3:0]       control;
    logic [CNT_W-1:0] counter;
    logic [7:0]       bus_out;
    logic             bus_oe;
    logic             busy;
    logic             done;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [2:0]       reg_idx;

    modport master (
        output date, stime, timer, wr_mode, wr_data, bus_in,
        input  control, counter, bus_out, bus_oe, busy, done, rd_data, rd_valid, reg_idx
    );

    modport slave (
        input  date, stime, timer, wr_mode, wr_data, bus_in,
        output control, counter, bus_out, bus_oe, busy, done, rd_data, rd_valid, reg_idx
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Turns a date/time/timer request into a burst of multiplexed address/data RTC transactions.
// Optional macro RTC_SEQ_COMMIT_EN appends a transfer-update write (0xF0 -> 0xF0) to write bursts.
module rtc_bus_sequencer #(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned T_PHASE    = 8,
    parameter int unsigned REGS       = 3,
    parameter logic [7:0]  DATE_BASE  = 8'h24,
    parameter logic [7:0]  TIME_BASE  = 8'h21,
    parameter logic [7:0]  TIMER_BASE = 8'h41
) (
    input logic               clk,
    input logic               reset,
    rtc_bus_sequencer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StAddr, StGap, StData, StRecov, StDone} state_e;

    localparam logic [CNT_W-1:0] AddrLast  = CNT_W'(T_PHASE - 1);
    localparam logic [CNT_W-1:0] GapLast   = CNT_W'(2 * T_PHASE - 1);
    localparam logic [CNT_W-1:0] DataFirst = CNT_W'(2 * T_PHASE);
    localparam logic [CNT_W-1:0] DataLast  = CNT_W'(3 * T_PHASE - 1);
    localparam logic [CNT_W-1:0] RecovLast = CNT_W'(4 * T_PHASE - 1);
    localparam logic [2:0]       LastIdx   = 3'(REGS - 1);
    localparam logic [7:0]       CommitByte = 8'hF0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       base_q, base_d;
    logic             wr_q, wr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             commit_q, commit_d;

    logic [3:0]       ctrl;
    logic [7:0]       bus_out_c;
    logic             bus_oe_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            base_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            commit_q   <= commit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        base_d     = base_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        commit_d   = commit_q;
        case (state_q)
            StIdle: begin
                if (bus.stime || bus.date || bus.timer) begin
                    state_d  = StAddr;
                    cnt_d    = '0;
                    idx_d    = '0;
                    wr_d     = bus.wr_mode;
                    commit_d = 1'b0;
                    base_d   = bus.stime ? TIME_BASE : (bus.date ? DATE_BASE : TIMER_BASE);
                end
            end
            StAddr: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AddrLast) state_d = StGap;
            end
            StGap: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GapLast) state_d = StData;
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DataFirst) wdata_d = bus.wr_data;
                if (cnt_q == DataLast) begin
                    state_d = StRecov;
                    if (!wr_q) begin
                        rd_data_d  = bus.bus_in;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            StRecov: begin
                if (cnt_q == RecovLast) begin
                    cnt_d = '0;
                    if (idx_q != LastIdx) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StAddr;
                    end else begin
`ifdef RTC_SEQ_COMMIT_EN
                        // Trailing transfer-update command on write bursts only, once.
                        if (wr_q && !commit_q) begin
                            commit_d = 1'b1;
                            state_d  = StAddr;
                        end else begin
                            state_d = StDone;
                        end
`else
                        state_d = StDone;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // control = {a_d, cs_n, rd_n, wr_n}
    always_comb begin
        ctrl      = 4'b0111;
        bus_out_c = '0;
        bus_oe_c  = 1'b0;
        case (state_q)
            StAddr: begin
                ctrl      = 4'b0010;
                bus_oe_c  = 1'b1;
                bus_out_c = commit_q ? CommitByte : base_q + {5'b0, idx_q};
            end
            StData: begin
                if (wr_q) begin
                    ctrl      = 4'b1010;
                    bus_oe_c  = 1'b1;
                    if (commit_q) bus_out_c = CommitByte;
                    else bus_out_c = (cnt_q == DataFirst) ? bus.wr_data : wdata_q;
                end else begin
                    ctrl = 4'b1001;
                end
            end
            StRecov: ctrl = 4'b1111;
            default: ;
        endcase
    end

    assign bus.control  = ctrl;
    assign bus.counter  = cnt_q;
    assign bus.bus_out  = bus_out_c;
    assign bus.bus_oe   = bus_oe_c;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.reg_idx  = idx_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: timeline model of each burst checked every cycle,
// plus directed scenarios with hand-computed addresses, data and latencies.
module tb_rtc_bus_sequencer;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned T_PHASE = 8;
    localparam int unsigned REGS    = 3;
    localparam int unsigned P4      = 4 * T_PHASE;
`ifdef RTC_SEQ_COMMIT_EN
    localparam bit COMMIT = 1'b1;
`else
    localparam bit COMMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rtc_bus_sequencer_if #(.CNT_W(CNT_W)) bus ();

    rtc_bus_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a burst is a timeline of ntx transactions of P4 cycles counted from the accept edge.
    bit          m_active, m_done, m_wr, m_rd_valid;
    int unsigned m_t, m_ntx;
    logic [7:0]  m_base, m_wdata, m_rd_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active   <= 1'b0;
            m_done     <= 1'b0;
            m_t        <= 0;
            m_rd_data  <= 8'h00;
            m_rd_valid <= 1'b0;
        end else begin
            m_rd_valid <= 1'b0;
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_active) begin
                if (m_t % P4 == 2 * T_PHASE) m_wdata <= bus.wr_data;
                if (!m_wr && (m_t % P4 == 3 * T_PHASE - 1)) begin
                    m_rd_data  <= bus.bus_in;
                    m_rd_valid <= 1'b1;
                end
                m_t <= m_t + 1;
                if (m_t + 1 == m_ntx * P4) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end else if (bus.stime || bus.date || bus.timer) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_wr     <= bus.wr_mode;
                m_ntx    <= (COMMIT && bus.wr_mode) ? REGS + 1 : REGS;
                m_base   <= bus.stime ? 8'h21 : (bus.date ? 8'h24 : 8'h41);
            end
        end
    end

    int unsigned e_txn, e_pos;
    logic [3:0]  e_ctrl;
    logic [7:0]  e_out;
    logic        e_oe;
    int unsigned e_idx, e_cnt;

    always_comb begin
        e_txn  = m_t / P4;
        e_pos  = m_t % P4;
        e_ctrl = 4'b0111;
        e_out  = 8'h00;
        e_oe   = 1'b0;
        e_cnt  = m_active ? e_pos : 0;
        e_idx  = m_active ? ((e_txn >= REGS) ? REGS - 1 : e_txn) : (m_done ? REGS - 1 : 0);
        if (m_active) begin
            case (e_pos / T_PHASE)
                0: begin
                    e_ctrl = 4'b0010;
                    e_oe   = 1'b1;
                    e_out  = (e_txn >= REGS) ? 8'hF0 : 8'(32'(m_base) + e_txn);
                end
                1: e_ctrl = 4'b0111;
                2: begin
                    if (m_wr) begin
                        e_ctrl = 4'b1010;
                        e_oe   = 1'b1;
                        if (e_txn >= REGS) e_out = 8'hF0;
                        else e_out = (e_pos == 2 * T_PHASE) ? bus.wr_data : m_wdata;
                    end else begin
                        e_ctrl = 4'b1001;
                    end
                end
                default: e_ctrl = 4'b1111;
            endcase
        end
    end

    // Per-cycle compare plus logging for the directed scenarios.
    logic [7:0] addr_log[$];
    logic [7:0] data_log[$];
    logic [7:0] rd_log[$];
    int start_cyc = 0;
    int last_lat = -1;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("control", 32'(bus.control), 32'(e_ctrl));
        check("counter", 32'(bus.counter), e_cnt);
        check("bus_oe", 32'(bus.bus_oe), 32'(e_oe));
        if (e_oe || !reset) check("bus_out", 32'(bus.bus_out), 32'(e_out));
        check("busy", 32'(bus.busy), 32'(m_active || m_done));
        check("done", 32'(bus.done), 32'(m_done));
        check("reg_idx", 32'(bus.reg_idx), e_idx);
        check("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        check("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
        if (bus.busy && !busy_prev) start_cyc = cyc;
        if (bus.done) last_lat = cyc - start_cyc;
        busy_prev = bus.busy;
        if (bus.control == 4'b0010 && bus.counter == 0) addr_log.push_back(bus.bus_out);
        if (bus.control == 4'b1010 && 32'(bus.counter) == 2 * T_PHASE)
            data_log.push_back(bus.bus_out);
        if (bus.rd_valid) rd_log.push_back(bus.rd_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        data_log.delete();
        rd_log.delete();
        last_lat = -1;
    endtask

    task automatic wait_busy(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string name, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_pos(input string name, input int idx, input int cnt);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (32'(bus.reg_idx) == idx && 32'(bus.counter) == cnt) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        bus.date = 1'b0; bus.stime = 1'b0; bus.timer = 1'b0;
        bus.wr_mode = 1'b0; bus.wr_data = 8'h00; bus.bus_in = 8'h00;
        repeat (3) step();
        reset = 1'b1;

        // Idle with no requests.
        repeat (20) step();
        check("idle_control", 32'(bus.control), 32'h7);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Time read burst.
        clear_logs();
        bus.stime = 1'b1; bus.wr_mode = 1'b0; bus.bus_in = 8'h59;
        wait_busy("rd_start");
        bus.stime = 1'b0;
        wait_done("rd_done", 200);
        check("rd_latency", 32'(last_lat), 32'd96);
        check("rd_naddr", 32'(addr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("rd_addr", 32'(addr_log[i]), 32'h21 + 32'(i));
        check("rd_npulse", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("rd_byte", 32'(rd_log[i]), 32'h59);

        // Date write burst.
        step();
        clear_logs();
        bus.date = 1'b1; bus.wr_mode = 1'b1; bus.wr_data = 8'h15;
        wait_busy("wr_start");
        bus.date = 1'b0;
        wait_done("wr_done", 200);
        for (int i = 0; i < 3; i++) check("wr_addr", 32'(addr_log[i]), 32'h24 + 32'(i));
        for (int i = 0; i < 3; i++) check("wr_byte", 32'(data_log[i]), 32'h15);
        check("wr_no_rd_valid", 32'(rd_log.size()), 32'd0);

        // All requests at once; stime dropped mid-burst, date stays up.
        step();
        clear_logs();
        bus.date = 1'b1; bus.stime = 1'b1; bus.timer = 1'b1; bus.wr_mode = 1'b0;
        wait_busy("prio_start");
        wait_pos("prio_mid", 0, 20);
        bus.stime = 1'b0; bus.timer = 1'b0;
        wait_done("prio_done", 200);
        check("prio_first_addr", 32'(addr_log[0]), 32'h21);
        check("prio_naddr", 32'(addr_log.size()), 32'd3);
        @(negedge clk); #1;
        check("gap_idle", 32'(bus.busy), 32'd0);
        @(negedge clk); #1;
        check("restart_busy", 32'(bus.busy), 32'd1);
        check("restart_addr", 32'(bus.bus_out), 32'h24);
        bus.date = 1'b0;
        wait_done("restart_done", 200);

        // Asynchronous reset in the middle of the second transaction.
        step();
        bus.stime = 1'b1;
        wait_busy("rst_start");
        bus.stime = 1'b0;
        wait_pos("rst_pos", 1, 12);
        reset = 1'b0;
        #1;
        check("rst_control", 32'(bus.control), 32'h7);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_counter", 32'(bus.counter), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk); #1;
        check("post_rst_counter", 32'(bus.counter), 32'd0);
        check("post_rst_idx", 32'(bus.reg_idx), 32'd0);

        // Timer write burst; carries the commit transaction when enabled.
        step();
        clear_logs();
        bus.timer = 1'b1; bus.wr_mode = 1'b1; bus.wr_data = 8'h3C;
        wait_busy("tmr_start");
        bus.timer = 1'b0;
        wait_done("tmr_done", 300);
        check("tmr_latency", 32'(last_lat), COMMIT ? 32'd128 : 32'd96);
        check("tmr_naddr", 32'(addr_log.size()), 32'(REGS) + 32'(COMMIT));
        check("tmr_first_addr", 32'(addr_log[0]), 32'h41);
        check("tmr_last_addr", 32'(addr_log[addr_log.size() - 1]), COMMIT ? 32'hF0 : 32'h43);
        check("tmr_last_data", 32'(data_log[data_log.size() - 1]), COMMIT ? 32'hF0 : 32'h3C);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.wr_data = 8'($urandom);
            bus.bus_in  = 8'($urandom);
            if ($urandom_range(0, 39) == 0)
                {bus.stime, bus.date, bus.timer, bus.wr_mode} = 4'($urandom);
        end
        bus.date = 1'b0; bus.stime = 1'b0; bus.timer = 1'b0;
        repeat (200) step();
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
